// File: rtl/egress_frame_scheduler.sv
// Egress frame scheduler: shares one egress AXI-stream among NUM_SRC ingress
// queues. A queue wins a whole frame at a time in round-robin order. A source
// that stops supplying beats mid-frame is cut off by a stall timeout, and the
// rest of its frame is drained and dropped.
//
// Stream handshake: a beat moves on a cycle where tvalid and tready are both
// high. tvalid never waits on tready. On the egress side a beat is held while
// egr_tready is low. On the ingress side src_tready is high only for the
// current owner, and only while that owner may move a beat.
module egress_frame_scheduler #(
    parameter int NUM_SRC        = 4,
    parameter int DATA_W         = 8,
    parameter int DEST_W         = 4,
    parameter int EGRESS_ID      = 0,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_SRC-1:0]        src_req,
    input  logic [NUM_SRC*DEST_W-1:0] src_dest,
    input  logic [NUM_SRC-1:0]        src_tvalid,
    input  logic [NUM_SRC*DATA_W-1:0] src_tdata,
    input  logic [NUM_SRC-1:0]        src_tlast,
    output logic [NUM_SRC-1:0]        src_tready,
    output logic                      egr_tvalid,
    output logic [DATA_W-1:0]         egr_tdata,
    output logic                      egr_tlast,
    input  logic                      egr_tready,
    output logic [NUM_SRC-1:0]        grant,
    output logic                      busy,
    output logic                      timeout_abort,
    output logic [15:0]               frames_sent
);

    localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int SW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [SW-1:0] STALL_MAX = SW'(TIMEOUT_CYCLES);
    localparam logic [PW-1:0] PTR_RESET = PW'(NUM_SRC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_XFER  = 2'd1,
        S_ABORT = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_SRC-1:0]   grant_q, grant_d;
    logic [PW-1:0]        owner_q, owner_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [SW-1:0]        stall_q, stall_d;
    logic [15:0]          frames_q, frames_d;

    logic [NUM_SRC-1:0]   elig;
    logic [DATA_W-1:0]    src_data_a [NUM_SRC];
    logic                 pick_found;
    logic [PW-1:0]        pick_idx;
    logic [PW-1:0]        cand;
    logic                 xfer_done;

    // Only the EGRESS_ID bit of each dest mask matters to this port.
    logic unused_dest;
    assign unused_dest = ^src_dest;

    // Per-queue eligibility and data unpacking.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            elig[i]       = src_req[i] & src_dest[i*DEST_W + EGRESS_ID];
            src_data_a[i] = src_tdata[i*DATA_W +: DATA_W];
        end
    end

    // Round-robin pick: first eligible queue searching upward from ptr+1.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand = PW'((int'(ptr_q) + k) % NUM_SRC);
            if (!pick_found && elig[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Next-state and output decode for the frame FSM.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        owner_d       = owner_q;
        ptr_d         = ptr_q;
        stall_d       = stall_q;
        frames_d      = frames_q;
        egr_tvalid    = 1'b0;
        egr_tdata     = '0;
        egr_tlast     = 1'b0;
        src_tready    = '0;
        timeout_abort = 1'b0;
        xfer_done     = 1'b0;

        case (state_q)
            S_IDLE: begin
                stall_d = '0;
                if (pick_found) begin
                    state_d           = S_XFER;
                    owner_d           = pick_idx;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                end
            end
            S_XFER: begin
                egr_tvalid          = src_tvalid[owner_q];
                egr_tdata           = src_data_a[owner_q];
                egr_tlast           = src_tlast[owner_q];
                src_tready[owner_q] = egr_tready;
                xfer_done = src_tvalid[owner_q] & src_tlast[owner_q] & egr_tready;
                // Only a missing source beat counts as starvation.
                if (src_tvalid[owner_q]) begin
                    stall_d = '0;
                end else if (stall_q != STALL_MAX) begin
                    stall_d = stall_q + 1'b1;
                end
                // A completing tlast beat takes precedence over the timeout.
                if (xfer_done) begin
                    state_d  = S_IDLE;
                    ptr_d    = owner_q;
                    grant_d  = '0;
                    frames_d = frames_q + 16'd1;
                end else if (TIMEOUT_CYCLES != 0 && stall_q == STALL_MAX) begin
                    state_d       = S_ABORT;
                    timeout_abort = 1'b1;
                end
            end
            S_ABORT: begin
                stall_d    = '0;
                egr_tvalid = 1'b1;
                egr_tlast  = 1'b1;
                if (egr_tready) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                stall_d             = '0;
                src_tready[owner_q] = 1'b1;
                if (src_tvalid[owner_q] & src_tlast[owner_q]) begin
                    state_d = S_IDLE;
                    ptr_d   = owner_q;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State registers; reset leaves queue 0 as top priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            grant_q  <= '0;
            owner_q  <= '0;
            ptr_q    <= PTR_RESET;
            stall_q  <= '0;
            frames_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            stall_q  <= stall_d;
            frames_q <= frames_d;
        end
    end

    assign grant       = grant_q;
    assign busy        = (state_q != S_IDLE);
    assign frames_sent = frames_q;

endmodule

// File: tb/tb_egress_frame_scheduler.sv
// Bench for egress_frame_scheduler: directed frames fed from per-queue
// source models, a per-cycle reference model compare, and literal checks
// for the grant order, egress beat sequences and abort timing.
module tb_egress_frame_scheduler;
    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int DESTW = 4;
    localparam int EG    = 0;
    localparam int TO    = 64;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    src_req;
    logic [N*DESTW-1:0] src_dest;
    logic [N-1:0]    src_tvalid;
    logic [N*DW-1:0] src_tdata;
    logic [N-1:0]    src_tlast;
    logic [N-1:0]    src_tready;
    logic            egr_tvalid;
    logic [DW-1:0]   egr_tdata;
    logic            egr_tlast;
    logic            egr_tready;
    logic [N-1:0]    grant;
    logic            busy;
    logic            timeout_abort;
    logic [15:0]     frames_sent;

    int tests_run    = 0;
    int tests_failed = 0;

    egress_frame_scheduler #(
        .NUM_SRC(N), .DATA_W(DW), .DEST_W(DESTW), .EGRESS_ID(EG), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(rst),
        .src_req(src_req), .src_dest(src_dest),
        .src_tvalid(src_tvalid), .src_tdata(src_tdata), .src_tlast(src_tlast),
        .src_tready(src_tready),
        .egr_tvalid(egr_tvalid), .egr_tdata(egr_tdata), .egr_tlast(egr_tlast),
        .egr_tready(egr_tready),
        .grant(grant), .busy(busy), .timeout_abort(timeout_abort),
        .frames_sent(frames_sent)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        tests_run++;
        tests_failed++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // ---------------- source models ----------------
    // Main owns mem/fdest/tail/ftail/stall_at; the source process owns head/fhead/popped.
    logic [8:0] mem   [N][64];
    logic [3:0] fdest [N][16];
    int head [N];
    int tail [N];
    int fhead[N];
    int ftail[N];
    int popped[N];
    int stall_at[N];
    int clr_gen = 0;

    initial begin
        bit pop [N];
        int seen_gen;
        seen_gen   = 0;
        src_req    = '0;
        src_dest   = '0;
        src_tvalid = '0;
        src_tdata  = '0;
        src_tlast  = '0;
        for (int i = 0; i < N; i++) begin
            head[i] = 0; fhead[i] = 0; popped[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) pop[i] = src_tvalid[i] && src_tready[i];
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (pop[i]) begin
                    if (mem[i][head[i] % 64][8]) fhead[i]++;
                    head[i]++;
                    popped[i]++;
                end
            end
            if (clr_gen != seen_gen) begin
                seen_gen = clr_gen;
                for (int i = 0; i < N; i++) begin
                    head[i] = tail[i]; fhead[i] = ftail[i]; popped[i] = 0;
                end
            end
            for (int i = 0; i < N; i++) begin
                bit ne;
                ne = (head[i] != tail[i]);
                src_tvalid[i] = ne && (stall_at[i] < 0 || popped[i] < stall_at[i]);
                src_tdata[i*DW +: DW] = ne ? mem[i][head[i] % 64][7:0] : 8'h00;
                src_tlast[i] = ne && mem[i][head[i] % 64][8];
                src_req[i] = (fhead[i] != ftail[i]);
                src_dest[i*DESTW +: DESTW] = (fhead[i] != ftail[i]) ? fdest[i][fhead[i] % 16] : 4'h0;
            end
        end
    end

    task automatic push_frame(input int q, input logic [3:0] dest, input int len, input logic [7:0] base);
        for (int b = 0; b < len; b++) begin
            mem[q][tail[q] % 64] = {(b == len - 1), 8'(base + b)};
            tail[q]++;
        end
        fdest[q][ftail[q] % 16] = dest;
        ftail[q]++;
    endtask

    // ---------------- reference model + per-cycle compare ----------------
    int m_phase = 0;   // 0 idle, 1 forwarding, 2 terminating beat, 3 draining
    int m_owner = -1;
    int m_ptr   = N - 1;
    int m_starve = 0;
    int m_frames = 0;

    int cyc = 0;
    int abort_cnt = 0;
    int abort_cyc = 0;
    int tr2_cnt = 0;
    int idle_run = 0;
    logic [8:0] cap_q[$];
    int cap_cyc[$];
    int gnt_log[$];
    int gap_log[$];
    logic [N-1:0] prev_grant = '0;

    always @(negedge clk) begin
        int g;
        bit done;
        bit found;
        int c;
        logic [N-1:0] e_grant, e_tready;
        logic e_v, e_l, e_ab;
        logic [DW-1:0] e_d;
        cyc++;
        if (rst) begin
            m_phase = 0; m_owner = -1; m_ptr = N - 1; m_starve = 0; m_frames = 0;
            chk("rst_grant", 32'(grant), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_egr_tvalid", 32'(egr_tvalid), 0);
            chk("rst_egr_tlast", 32'(egr_tlast), 0);
            chk("rst_egr_tdata", 32'(egr_tdata), 0);
            chk("rst_src_tready", 32'(src_tready), 0);
            chk("rst_timeout_abort", 32'(timeout_abort), 0);
            chk("rst_frames_sent", 32'(frames_sent), 0);
            prev_grant = '0;
        end else begin
            g = (m_owner < 0) ? 0 : m_owner;
            e_v = 1'b0; e_l = 1'b0; e_d = '0; e_tready = '0; e_ab = 1'b0;
            done = (m_phase == 1) && src_tvalid[g] && egr_tready && src_tlast[g];
            case (m_phase)
                1: begin
                    e_v = src_tvalid[g];
                    e_d = src_tdata[g*DW +: DW];
                    e_l = src_tlast[g];
                    e_tready = egr_tready ? N'(1 << g) : '0;
                    e_ab = (TO != 0) && (m_starve >= TO) && !done;
                end
                2: begin e_v = 1'b1; e_l = 1'b1; end
                3: e_tready = N'(1 << g);
                default: ;
            endcase
            e_grant = (m_phase != 0) ? N'(1 << g) : '0;
            chk("cyc_grant", 32'(grant), 32'(e_grant));
            chk("cyc_busy", 32'(busy), 32'(m_phase != 0));
            chk("cyc_egr_tvalid", 32'(egr_tvalid), 32'(e_v));
            chk("cyc_egr_tdata", 32'(egr_tdata), 32'(e_d));
            chk("cyc_egr_tlast", 32'(egr_tlast), 32'(e_l));
            chk("cyc_src_tready", 32'(src_tready), 32'(e_tready));
            chk("cyc_timeout_abort", 32'(timeout_abort), 32'(e_ab));
            chk("cyc_frames_sent", 32'(frames_sent), 32'(m_frames));

            // observation logs used by the directed checks
            if (egr_tvalid && egr_tready) begin
                cap_q.push_back({egr_tlast, egr_tdata});
                cap_cyc.push_back(cyc);
            end
            if (timeout_abort) begin abort_cnt++; abort_cyc = cyc; end
            if (src_tready[2]) tr2_cnt++;
            if (grant != 0) begin
                if (prev_grant == 0) begin
                    for (int i = 0; i < N; i++) if (grant[i]) gnt_log.push_back(i);
                    gap_log.push_back(idle_run);
                end
                idle_run = 0;
            end else begin
                idle_run++;
            end
            prev_grant = grant;

            // advance the model to the next cycle
            case (m_phase)
                0: begin
                    found = 1'b0;
                    for (int k = 1; k <= N; k++) begin
                        c = (m_ptr + k) % N;
                        if (!found && src_req[c] && src_dest[c*DESTW + EG]) begin
                            found = 1'b1; m_owner = c;
                        end
                    end
                    if (found) begin m_phase = 1; m_starve = 0; end
                end
                1: begin
                    if (done) begin
                        m_frames = (m_frames + 1) % 65536;
                        m_ptr = g; m_phase = 0; m_owner = -1;
                    end else if (TO != 0 && m_starve >= TO) begin
                        m_phase = 2;
                    end else if (src_tvalid[g]) begin
                        m_starve = 0;
                    end else if (m_starve < TO) begin
                        m_starve++;
                    end
                end
                2: if (egr_tready) m_phase = 3;
                3: if (src_tvalid[g] && src_tlast[g]) begin
                    m_phase = 0; m_ptr = g; m_owner = -1;
                end
                default: ;
            endcase
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clr_gen++;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic wait_frames(input string name, input int target, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (frames_sent == 16'(target)) begin ok = 1'b1; break; end
            tick();
        end
        if (!ok) bound_fail(name);
    endtask

    task automatic wait_caps(input string name, input int target, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (cap_q.size() >= target) begin ok = 1'b1; break; end
            tick();
        end
        if (!ok) bound_fail(name);
    endtask

    // compare captured egress beats from index base against exp_q
    logic [8:0] exp_q[$];
    task automatic check_caps(input string name, input int base);
        chk({name, "_count"}, 32'(cap_q.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < cap_q.size()) chk({name, "_beat"}, 32'(cap_q[base + i]), 32'(exp_q[i]));
        end
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int cb, gb, ab0, t2b;
        bit ok;
        egr_tready = 1'b1;
        for (int i = 0; i < N; i++) begin
            tail[i] = 0; ftail[i] = 0; stall_at[i] = -1;
        end

        // reset values
        rst = 1'b1;
        tick(); tick();
        chk("t1_grant", 32'(grant), 0);
        chk("t1_frames", 32'(frames_sent), 0);
        rst = 1'b0;
        tick();

        // single 3-beat frame on queue 0
        cb = cap_q.size();
        push_frame(0, 4'b0001, 3, 8'hA1);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (src_req[0]) begin ok = 1'b1; break; end
        end
        if (!ok) bound_fail("t2_req_seen");
        chk("t2_grant_not_yet", 32'(grant), 0);
        @(negedge clk);
        chk("t2_grant_next_cycle", 32'(grant), 32'h1);
        chk("t2_first_beat", 32'(egr_tdata), 32'hA1);
        tick();
        wait_frames("t2_frames", 1, 50);
        tick();
        chk("t2_frames_sent", 32'(frames_sent), 1);
        chk("t2_grant_after", 32'(grant), 0);
        exp_q.delete();
        exp_q.push_back({1'b0, 8'hA1}); exp_q.push_back({1'b0, 8'hA2}); exp_q.push_back({1'b1, 8'hA3});
        check_caps("t2_caps", cb);

        // all queues request continuously with single-beat frames
        do_reset();
        cb = cap_q.size(); gb = gnt_log.size();
        for (int q = 0; q < N; q++) begin
            push_frame(q, 4'b0001, 1, 8'(8'h30 + q));
            push_frame(q, 4'b0001, 1, 8'(8'h40 + q));
        end
        wait_frames("t3_frames", 8, 200);
        tick();
        t2b = gnt_log.size() - gb;
        chk("t3_grant_count", 32'(t2b), 8);
        for (int i = 0; i < 8; i++) begin
            if (gb + i < gnt_log.size()) chk("t3_grant_order", 32'(gnt_log[gb + i]), 32'(i % N));
        end
        for (int i = 1; i < 8; i++) begin
            if (gb + i < gap_log.size()) chk("t3_idle_gap", 32'(gap_log[gb + i]), 1);
        end
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, 8'((i < 4 ? 8'h30 : 8'h40) + (i % 4))});
        check_caps("t3_caps", cb);

        // queue 2 not addressed to this port, queue 1 is
        cb = cap_q.size(); gb = gnt_log.size(); ab0 = tr2_cnt;
        push_frame(2, 4'b0010, 2, 8'h50);
        push_frame(1, 4'b0001, 2, 8'hB1);
        wait_frames("t4_frames", 9, 100);
        repeat (20) tick();
        chk("t4_grant_count", 32'(gnt_log.size() - gb), 1);
        if (gb < gnt_log.size()) chk("t4_granted_q1", 32'(gnt_log[gb]), 1);
        chk("t4_q2_tready_never", 32'(tr2_cnt - ab0), 0);
        exp_q.delete();
        exp_q.push_back({1'b0, 8'hB1}); exp_q.push_back({1'b1, 8'hB2});
        check_caps("t4_caps", cb);

        // long egress backpressure mid-frame is not starvation
        cb = cap_q.size(); ab0 = abort_cnt;
        push_frame(3, 4'b0001, 3, 8'hC1);
        wait_caps("t5_first_beat", cb + 1, 50);
        egr_tready = 1'b0;
        repeat (50) tick();
        chk("t5_hold_valid", 32'(egr_tvalid), 1);
        chk("t5_hold_data", 32'(egr_tdata), 32'hC2);
        repeat (50) tick();
        chk("t5_hold_data_late", 32'(egr_tdata), 32'hC2);
        chk("t5_no_abort", 32'(abort_cnt - ab0), 0);
        egr_tready = 1'b1;
        wait_frames("t5_frames", 10, 50);
        exp_q.delete();
        exp_q.push_back({1'b0, 8'hC1}); exp_q.push_back({1'b0, 8'hC2}); exp_q.push_back({1'b1, 8'hC3});
        check_caps("t5_caps", cb);

        // source starvation: abort, drain, then queue 1 served
        do_reset();
        cb = cap_q.size(); gb = gnt_log.size(); ab0 = abort_cnt;
        stall_at[0] = 1;
        push_frame(0, 4'b0001, 3, 8'hD1);
        push_frame(1, 4'b0001, 1, 8'hE1);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (abort_cnt != ab0) begin ok = 1'b1; break; end
            tick();
        end
        if (!ok) bound_fail("t6_abort_seen");
        if (ok && cb < cap_cyc.size()) chk("t6_abort_delay", 32'(abort_cyc - cap_cyc[cb]), 65);
        stall_at[0] = -1;
        wait_frames("t6_frames", 1, 100);
        repeat (3) tick();
        chk("t6_abort_once", 32'(abort_cnt - ab0), 1);
        chk("t6_frames_sent", 32'(frames_sent), 1);
        chk("t6_q0_drained", 32'(src_tvalid[0]), 0);
        exp_q.delete();
        exp_q.push_back({1'b0, 8'hD1}); exp_q.push_back({1'b1, 8'h00}); exp_q.push_back({1'b1, 8'hE1});
        check_caps("t6_caps", cb);
        chk("t6_grant_count", 32'(gnt_log.size() - gb), 2);
        if (gb + 1 < gnt_log.size()) begin
            chk("t6_grant_first", 32'(gnt_log[gb]), 0);
            chk("t6_grant_second", 32'(gnt_log[gb + 1]), 1);
        end

        // asynchronous reset on the second beat of a frame
        cb = cap_q.size();
        push_frame(0, 4'b0001, 3, 8'hF1);
        wait_caps("t7_first_beat", cb + 1, 50);
        chk("t7_pre_frames", 32'(frames_sent), 1);
        chk("t7_pre_grant", 32'(grant), 32'h1);
        #1;
        rst = 1'b1;
        #1;
        chk("t7_async_grant", 32'(grant), 0);
        chk("t7_async_valid", 32'(egr_tvalid), 0);
        chk("t7_async_frames", 32'(frames_sent), 0);
        chk("t7_async_busy", 32'(busy), 0);
        clr_gen++;
        tick(); tick();
        rst = 1'b0;
        tick();
        gb = gnt_log.size();
        push_frame(2, 4'b0001, 1, 8'h72);
        push_frame(0, 4'b0001, 1, 8'h70);
        wait_frames("t7_frames", 2, 50);
        chk("t7_grant_count", 32'(gnt_log.size() - gb), 2);
        if (gb + 1 < gnt_log.size()) begin
            chk("t7_first_after_reset", 32'(gnt_log[gb]), 0);
            chk("t7_second_after_reset", 32'(gnt_log[gb + 1]), 2);
        end
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
